// File: rtl/router_pkg.sv
// Shared definitions for the router1x3 packet path: header field widths, address encoding
// and the transmitter state type.
package router_pkg;

    localparam int HDR_LEN_W  = 6;
    localparam int HDR_ADDR_W = 2;
    localparam int MAX_LEN    = 63;

    localparam logic [HDR_ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } tx_state_t;

    // Header byte: length in the upper six bits, destination port in the lower two.
    function automatic logic [7:0] make_header(input logic [HDR_LEN_W-1:0]  len,
                                               input logic [HDR_ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer for the packet transmitter: one write port, one combinational read port.
module router_tx_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // NOTE: the array has no reset; every entry is written during LOAD before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for router1x3: buffers a whole payload, then sends header, payload and parity
// back-to-back under router busy, and watches the router error flag after each packet.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN  = router_pkg::MAX_LEN,
    parameter int ERR_WAIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       cmd_bad_par,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       busy,
    input  logic       error,
    output logic       cmd_reject,
    output logic       tx_done,
    output logic       tx_err,
    output logic [7:0] err_cnt
);

    tx_state_t              state;
    logic [HDR_LEN_W-1:0]   len_q;
    logic [HDR_ADDR_W-1:0]  addr_q;
    logic                   bad_par_q;
    logic [7:0]             par_acc;
    logic [HDR_LEN_W-1:0]   idx;
    logic [7:0]             gap_cnt;
    logic                   err_seen;
    logic [7:0]             rd_data;
    logic                   buf_we;
    logic                   err_now;

    assign buf_we  = (state == LOAD) && pl_valid && pl_ready;
    assign err_now = err_seen | error;

    // idx is the write pointer in LOAD and the next-byte-to-present pointer afterwards.
    router_tx_buf #(
        .DEPTH (MAX_LEN + 1),
        .AW    (HDR_LEN_W)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx),
        .wdata (pl_data),
        .raddr (idx),
        .rdata (rd_data)
    );

    // NOTE: every register uses non-blocking assignments so all branches see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pkt_data   <= '0;
            pkt_valid  <= 1'b0;
            cmd_ready  <= 1'b0;
            pl_ready   <= 1'b0;
            cmd_reject <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            err_cnt    <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            bad_par_q  <= 1'b0;
            par_acc    <= '0;
            idx        <= '0;
            gap_cnt    <= '0;
            err_seen   <= 1'b0;
        end else begin
            cmd_reject <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        len_q     <= cmd_len;
                        addr_q    <= cmd_addr;
                        bad_par_q <= cmd_bad_par;
                        par_acc   <= '0;
                        idx       <= '0;
                        if (cmd_addr == ADDR_INVALID || cmd_len == '0) begin
                            cmd_reject <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            cmd_ready <= 1'b0;
                            pl_ready  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (pl_valid && pl_ready) begin
                        par_acc <= par_acc ^ pl_data;
                        idx     <= idx + 6'd1;
                        if (idx == len_q - 6'd1) begin
                            pl_ready  <= 1'b0;
                            idx       <= '0;
                            pkt_valid <= 1'b1;
                            pkt_data  <= make_header(len_q, addr_q);
                            state     <= HEADER;
                        end
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        par_acc  <= par_acc ^ pkt_data;
                        pkt_data <= rd_data;
                        idx      <= idx + 6'd1;
                        state    <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        // idx == len_q means the byte now on the wire is the last payload byte.
                        if (idx == len_q) begin
                            pkt_valid <= 1'b0;
                            pkt_data  <= bad_par_q ? ~par_acc : par_acc;
                            state     <= PARITY;
                        end else begin
                            pkt_data <= rd_data;
                            idx      <= idx + 6'd1;
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        pkt_data <= '0;
                        gap_cnt  <= '0;
                        err_seen <= 1'b0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    err_seen <= err_now;
                    gap_cnt  <= gap_cnt + 8'd1;
                    if (gap_cnt == 8'(ERR_WAIT - 1)) begin
                        tx_done   <= 1'b1;
                        tx_err    <= err_now;
                        if (err_now && err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: stimulus pushes expected wire bytes and completion records,
// a negedge monitor pops and compares them, and a small router model raises error on bad parity.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_addr = '0;
    logic [5:0] cmd_len = '0;
    logic       cmd_bad_par = 1'b0;
    logic       pl_valid = 1'b0;
    logic       pl_ready;
    logic [7:0] pl_data = '0;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       busy = 1'b0;
    logic       error = 1'b0;
    logic       cmd_reject;
    logic       tx_done;
    logic       tx_err;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    router_pkt_tx dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_bad_par (cmd_bad_par),
        .pl_valid    (pl_valid),
        .pl_ready    (pl_ready),
        .pl_data     (pl_data),
        .pkt_data    (pkt_data),
        .pkt_valid   (pkt_valid),
        .busy        (busy),
        .error       (error),
        .cmd_reject  (cmd_reject),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .err_cnt     (err_cnt)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] wire_q[$];   // {pkt_valid, pkt_data} of each consumed byte
    logic [8:0] done_q[$];   // {tx_err, err_cnt} at each tx_done
    int         rej_pending = 0;
    logic [7:0] pl_bytes[64];
    logic [7:0] exp_cnt = '0;
    bit         err_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got 0x%0h, expected nothing", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] addr, input logic [5:0] len, input bit bad);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            tick();
            t++;
        end
        if (!cmd_ready) fail_now("cmd_ready_timeout", cmd_ready);
        cmd_valid   = 1'b1;
        cmd_addr    = addr;
        cmd_len     = len;
        cmd_bad_par = bad;
        tick();
        cmd_valid   = 1'b0;
    endtask

    // Pushes the expected packet (unless push=0), issues the command and loads the payload.
    task automatic send_pkt(input logic [1:0] addr, input logic [5:0] len, input bit bad,
                            input bit toggle, input bit push);
        logic [7:0] par;
        int         i = 0;
        int         t = 0;
        bit         phase = 1'b0;
        bit         hs;
        if (push) begin
            par = {len, addr};
            wire_q.push_back({1'b1, par});
            for (int k = 0; k < int'(len); k++) begin
                wire_q.push_back({1'b1, pl_bytes[k]});
                par ^= pl_bytes[k];
            end
            wire_q.push_back({1'b0, bad ? ~par : par});
            if (bad && exp_cnt != 8'hFF) exp_cnt++;
            done_q.push_back({bad, exp_cnt});
        end
        send_cmd(addr, len, bad);
        while (i < int'(len) && t < 1000) begin
            if (toggle && phase) begin
                pl_valid = 1'b0;
                tick();
            end else begin
                pl_valid = 1'b1;
                pl_data  = pl_bytes[i];
                hs       = pl_ready;
                tick();
                if (hs) i++;
            end
            phase = ~phase;
            t++;
        end
        pl_valid = 1'b0;
        if (i < int'(len)) fail_now("payload_load_timeout", i);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!tx_done && t < 500) begin
            tick();
            t++;
        end
        if (!tx_done) fail_now("tx_done_timeout", tx_done);
        tick();
    endtask

    // Monitor and router model: a byte is consumed on an edge with busy=0 while pkt_valid is
    // high, or for the parity byte that follows the last valid byte.
    initial begin
        bit         in_pkt = 1'b0;
        bit         hold_ok = 1'b0;
        logic [8:0] hold_val = '0;
        logic [8:0] act;
        logic [7:0] rx_par = '0;
        forever begin
            @(negedge clk);
            act = {pkt_valid, pkt_data};
            if (reset) begin
                in_pkt  = 1'b0;
                hold_ok = 1'b0;
            end else begin
                if (hold_ok) check("stall_hold", act, hold_val);
                hold_ok = 1'b0;
                if (pkt_valid || in_pkt) begin
                    if (busy) begin
                        hold_ok  = 1'b1;
                        hold_val = act;
                    end else begin
                        if (wire_q.size() == 0) fail_now("wire_unexpected", act);
                        else check("wire_byte", act, wire_q.pop_front());
                        if (pkt_valid) begin
                            rx_par = in_pkt ? (rx_par ^ pkt_data) : pkt_data;
                            in_pkt = 1'b1;
                        end else begin
                            if (pkt_data != rx_par) err_req = 1'b1;
                            in_pkt = 1'b0;
                        end
                    end
                end
                if (tx_done) begin
                    if (done_q.size() == 0) fail_now("tx_done_unexpected", {tx_err, err_cnt});
                    else check("tx_done_err_cnt", {tx_err, err_cnt}, done_q.pop_front());
                end else if (tx_err) begin
                    fail_now("tx_err_without_done", tx_err);
                end
                if (cmd_reject) begin
                    if (rej_pending == 0) fail_now("cmd_reject_unexpected", cmd_reject);
                    else rej_pending--;
                end
            end
        end
    end

    // Router error output: one-cycle pulse just after a parity byte that did not match.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            error   = err_req;
            err_req = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        // Reset state
        repeat (3) tick();
        check("rst_pkt_valid", pkt_valid, 1'b0);
        check("rst_pkt_data", pkt_data, 8'h00);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_pl_ready", pl_ready, 1'b0);
        check("rst_err_cnt", err_cnt, 8'h00);
        check("rst_tx_done", tx_done, 1'b0);
        reset = 1'b0;
        tick();
        check("cmd_ready_after_rst", cmd_ready, 1'b1);

        // Test 1: addr 1, len 3, no stalls
        pl_bytes[0] = 8'h11; pl_bytes[1] = 8'h22; pl_bytes[2] = 8'h33;
        send_pkt(2'd1, 6'd3, 1'b0, 1'b0, 1'b1);
        wait_done();

        // Test 2: same packet, busy for 2 cycles on header and 1 cycle on parity
        send_pkt(2'd1, 6'd3, 1'b0, 1'b0, 1'b1);
        t = 0;
        while (!pkt_valid && t < 100) begin tick(); t++; end
        check("t2_header_seen", pkt_valid, 1'b1);
        busy = 1'b1;
        tick();
        tick();
        busy = 1'b0;
        t = 0;
        while (pkt_valid && t < 100) begin tick(); t++; end
        busy = 1'b1;
        tick();
        busy = 1'b0;
        wait_done();

        // Test 3: invalid commands are rejected and never reach LOAD
        rej_pending++;
        send_cmd(2'd3, 6'd5, 1'b0);
        tick();
        check("t3_pl_ready_addr3", pl_ready, 1'b0);
        rej_pending++;
        send_cmd(2'd0, 6'd0, 1'b0);
        tick();
        tick();
        check("t3_pl_ready_len0", pl_ready, 1'b0);
        check("t3_pkt_valid", pkt_valid, 1'b0);
        check("t3_rejects_seen", rej_pending, 0);
        check("t3_cmd_ready", cmd_ready, 1'b1);

        // Test 4: maximum length with 50% payload gaps
        for (int k = 0; k < 63; k++) pl_bytes[k] = 8'(k * 7 + 3);
        send_pkt(2'd2, 6'd63, 1'b0, 1'b1, 1'b1);
        wait_done();

        // Test 5: injected bad parity triggers router error
        pl_bytes[0] = 8'hA5;
        send_pkt(2'd0, 6'd1, 1'b1, 1'b0, 1'b1);
        wait_done();
        check("t5_err_cnt", err_cnt, 8'd1);

        // Test 6: reset while payload byte 5 of 10 is on the wire
        for (int k = 0; k < 10; k++) pl_bytes[k] = 8'(8'h60 + k);
        wire_q.push_back({1'b1, 8'h29});
        for (int k = 0; k < 5; k++) wire_q.push_back({1'b1, pl_bytes[k]});
        send_pkt(2'd1, 6'd10, 1'b0, 1'b0, 1'b0);
        t = 0;
        while (!(pkt_valid && pkt_data == 8'h65) && t < 100) begin tick(); t++; end
        check("t6_byte5_seen", {pkt_valid, pkt_data}, {1'b1, 8'h65});
        busy  = 1'b1;
        reset = 1'b1;
        tick();
        check("t6_pkt_valid_rst", pkt_valid, 1'b0);
        check("t6_cmd_ready_rst", cmd_ready, 1'b0);
        check("t6_bytes_before_rst", wire_q.size(), 0);
        reset   = 1'b0;
        busy    = 1'b0;
        exp_cnt = '0;
        tick();
        check("t6_cmd_ready_rel", cmd_ready, 1'b1);
        check("t6_err_cnt_rst", err_cnt, 8'd0);
        pl_bytes[0] = 8'hC3; pl_bytes[1] = 8'h3C;
        send_pkt(2'd0, 6'd2, 1'b0, 1'b0, 1'b1);
        wait_done();

        repeat (5) tick();
        check("end_wire_q_empty", wire_q.size(), 0);
        check("end_done_q_empty", done_q.size(), 0);
        check("end_rejects_empty", rej_pending, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
